// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO registers.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (codes 6-9).
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_op, w_op;
    logic [31:0]   r_a, w_a, r_b, w_b;
    logic [31:0]   r_hi, w_hi, r_lo, w_lo;

    logic          w_is_mul_in, w_is_div_in, w_op_is_div;
    logic [CW-1:0] w_last;
    logic          w_signed, w_neg_a, w_neg_b;
    logic [63:0]   w_ext_a, w_ext_b, w_prod;
    logic [31:0]   w_abs_a, w_abs_b, w_uq, w_ur, w_q, w_r;
    logic [31:0]   w_res_hi, w_res_lo;

    always_comb begin
        w_is_div_in = (MDOp == 4'd2) || (MDOp == 4'd3);
`ifdef MDU_MADD_EN
        w_is_mul_in = (MDOp <= 4'd1) || ((MDOp >= 4'd6) && (MDOp <= 4'd9));
`else
        w_is_mul_in = (MDOp <= 4'd1);
`endif
        w_op_is_div = (r_op == 4'd2) || (r_op == 4'd3);
        w_last      = w_op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end

    // Even codes are the signed variants (mult, div, madd, msub)
    always_comb begin
        w_signed = ~r_op[0];
        w_neg_a  = w_signed & r_a[31];
        w_neg_b  = w_signed & r_b[31];
        w_ext_a  = {{32{w_neg_a}}, r_a};
        w_ext_b  = {{32{w_neg_b}}, r_b};
        w_prod   = w_ext_a * w_ext_b;
        w_abs_a  = w_neg_a ? -r_a : r_a;
        w_abs_b  = w_neg_b ? -r_b : r_b;
        w_uq     = w_abs_a / w_abs_b;
        w_ur     = w_abs_a % w_abs_b;
        w_q      = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
        w_r      = w_neg_a ? -w_ur : w_ur;
    end

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            4'd0, 4'd1: {w_res_hi, w_res_lo} = w_prod;
            4'd2, 4'd3: begin
                // Divide by zero leaves HI/LO untouched
                if (r_b != '0) begin
                    w_res_lo = w_q;
                    w_res_hi = w_r;
                end
            end
`ifdef MDU_MADD_EN
            4'd6, 4'd7: {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod;
            4'd8, 4'd9: {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod;
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_op    = r_op;
        w_a     = r_a;
        w_b     = r_b;
        w_hi    = r_hi;
        w_lo    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (Start && !Cancel) begin
                    if (MDOp == 4'd4) begin
                        w_hi = SrcA;
                    end else if (MDOp == 4'd5) begin
                        w_lo = SrcA;
                    end else if (w_is_mul_in || w_is_div_in) begin
                        w_state = S_BUSY;
                        w_cnt   = CW'(1);
                        w_op    = MDOp;
                        w_a     = SrcA;
                        w_b     = SrcB;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == w_last) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_hi    = w_res_hi;
                    w_lo    = w_res_lo;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_op    <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
        end
    end

    assign Busy = (r_state == S_BUSY);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
